// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Bundles the core request/response handshake and the word-wide
//             data-memory bus of the load/store unit.
//  Ports    : master - the load/store unit (drives req_ready, resp_*, mem_*
//                      strobes/address/wdata; samples req_*, mem_rdata,
//                      mem_stall)
//             slave  - the surrounding core + memory system
//  Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  // core side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  // memory side
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] byte_address;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_stall;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_stall,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read, mem_write, byte_address, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_stall,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_read, mem_write, byte_address, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Accepts one load/store at a time from the core and turns it into
//             word-granular mem_read/mem_write accesses. Sub-word stores are a
//             read-modify-write. Loads return sign/zero-extended data.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous, active-low
//             bus   - load_store_unit_if.master (request, response, memory bus)
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input wire               clk,
  input wire               reset,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;    // byte offset within the word
  logic [15:0]           wdata_q, wdata_d;      // only sub-word stores need it
  logic                  req_ready_q, req_ready_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] byte_address_q, byte_address_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;

  logic                  accept;
  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_data;
  logic [31:0]           merged_word;

  // Request classification, evaluated on the incoming request.
  always_comb begin
    accept = bus.req_valid && req_ready_q;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = bus.req_write;  // no unsigned stores
      default:                req_illegal = 1'b1;
    endcase
    // funct3[1:0] encodes the access size for every legal code
    req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    byte_lane = bus.mem_rdata[{offset_q, 3'b000} +: 8];
    half_lane = bus.mem_rdata[{offset_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_data = {24'h000000, byte_lane};
      3'b101:  load_data = {16'h0000, half_lane};
      default: load_data = bus.mem_rdata;
    endcase
    merged_word = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merged_word[{offset_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged_word[{offset_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  // Next-state and registered-output logic; everything holds by default so
  // a stalled access keeps its strobe, address and data stable.
  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    funct3_d       = funct3_q;
    offset_d       = offset_q;
    wdata_d        = wdata_q;
    req_ready_d    = req_ready_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    byte_address_d = byte_address_q;
    mem_wdata_d    = mem_wdata_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_error_d   = resp_error_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d        = bus.req_write;
          funct3_d       = bus.req_funct3;
          offset_d       = bus.req_addr[1:0];
          wdata_d        = bus.req_wdata[15:0];
          byte_address_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          req_ready_d    = 1'b0;
          if (req_illegal || req_misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
            state_d     = S_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = bus.req_wdata;
          end else begin
            // loads and sub-word stores both start by reading the word
            state_d    = S_RD;
            mem_read_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (!bus.mem_stall) begin
          mem_read_d = 1'b0;
          if (write_q) begin
            state_d     = S_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = merged_word;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_rdata_d = load_data;
          end
        end
      end
      S_WR: begin
        if (!bus.mem_stall) begin
          mem_write_d  = 1'b0;
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      S_RESP: begin
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      write_q        <= 1'b0;
      funct3_q       <= 3'b000;
      offset_q       <= 2'b00;
      wdata_q        <= 16'h0000;
      req_ready_q    <= 1'b1;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      byte_address_q <= '0;
      mem_wdata_q    <= 32'h0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
      resp_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      funct3_q       <= funct3_d;
      offset_q       <= offset_d;
      wdata_q        <= wdata_d;
      req_ready_q    <= req_ready_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      byte_address_q <= byte_address_d;
      mem_wdata_q    <= mem_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_error_q   <= resp_error_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mem_read     = mem_read_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.byte_address = byte_address_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_error   = resp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed bench for load_store_unit. A transaction-level model
//             turns each request into an expected per-cycle trace; one compare
//             process checks every output every cycle against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  localparam int AW = 12;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_unit #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Memory environment, and the model's own copy of what memory should hold.
  logic [31:0] mem       [0:1023];
  logic [31:0] model_mem [0:1023];
  assign bus.mem_rdata = mem[bus.byte_address[AW-1:2]];
  always @(posedge clk)
    if (bus.mem_write && !bus.mem_stall) mem[bus.byte_address[AW-1:2]] <= bus.mem_wdata;

  int cyc = 0;
  bit rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset;
  end

  typedef struct {
    int          cyc;
    bit          rd;
    bit          wr;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    bit          resp;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  bit          last_err   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic exp_t mk(int c, bit rd, bit wr, logic [AW-1:0] a, logic [31:0] wd,
                              bit resp, logic [31:0] rdv, bit er);
    exp_t e;
    logic [AW-1:0] wa;
    wa = a;
    wa[1:0] = 2'b00;
    e.cyc = c; e.rd = rd; e.wr = wr; e.addr = wa; e.wdata = wd;
    e.resp = resp; e.rdata = rdv; e.err = er;
    return e;
  endfunction

  // ---------------- specification-level model ----------------
  function automatic int unsigned acc_size(logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_error(bit wr, logic [2:0] f3, logic [AW-1:0] a);
    bit legal;
    int unsigned ai;
    ai = a;
    if (wr) legal = f3 inside {3'd0, 3'd1, 3'd2};
    else    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (!legal) return 1'b1;
    return (ai % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [AW-1:0] a, logic [31:0] w);
    int unsigned off;
    logic [31:0] v;
    off = a % 4;
    v = w >> (8 * off);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_merge(logic [2:0] f3, logic [AW-1:0] a,
                                              logic [31:0] w, logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    mask = (acc_size(f3) == 1) ? 32'hFF : 32'hFFFF;
    sh = 8 * (a % 4);
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    exp_t e;
    bit   have;
    if (chk_en) begin
      have = 1'b0;
      if (rst_seen) begin
        last_rdata = 32'h0;
        last_err   = 1'b0;
      end
      e = mk(cyc, 1'b0, 1'b0, '0, 32'h0, 1'b0, last_rdata, last_err);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        have = 1'b1;
      end
      if (!e.resp) begin
        e.rdata = last_rdata;
        e.err   = last_err;
      end
      chk("req_ready",  {31'b0, bus.req_ready},  {31'b0, !have});
      chk("mem_read",   {31'b0, bus.mem_read},   {31'b0, e.rd});
      chk("mem_write",  {31'b0, bus.mem_write},  {31'b0, e.wr});
      chk("resp_valid", {31'b0, bus.resp_valid}, {31'b0, e.resp});
      chk("resp_rdata", bus.resp_rdata, e.rdata);
      chk("resp_error", {31'b0, bus.resp_error}, {31'b0, e.err});
      if (e.rd || e.wr) chk("byte_address", {20'b0, bus.byte_address}, {20'b0, e.addr});
      if (e.wr)         chk("mem_wdata", bus.mem_wdata, e.wdata);
      if (e.resp) begin
        last_rdata = e.rdata;
        last_err   = e.err;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the idle
  // cycle after RESP. Stall counts apply to the read / write phases.
  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [31:0] wd, input int st_rd, input int st_wr);
    int c, k, widx;
    bit plan[$];
    logic [31:0] word, nword;
    c = cyc;
    k = c + 1;
    widx = a >> 2;
    word = model_mem[widx];
    if (model_error(wr, f3, a)) begin
      q.push_back(mk(k, 0, 0, a, 0, 1, 32'h0, 1)); plan.push_back(1'b1); k++;
    end else begin
      if (!wr || f3 != 3'd2) begin
        for (int j = 0; j <= st_rd; j++) begin
          q.push_back(mk(k, 1, 0, a, 0, 0, 0, 0)); plan.push_back(j < st_rd); k++;
        end
      end
      if (wr) begin
        nword = (f3 == 3'd2) ? wd : model_merge(f3, a, word, wd);
        for (int j = 0; j <= st_wr; j++) begin
          q.push_back(mk(k, 0, 1, a, nword, 0, 0, 0)); plan.push_back(j < st_wr); k++;
        end
        model_mem[widx] = nword;
      end
      q.push_back(mk(k, 0, 0, a, 0, 1, wr ? 32'h0 : model_load(f3, a, word), 0));
      plan.push_back(1'b1);  // stall during RESP must be ignored
      k++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    foreach (plan[j]) begin
      bus.mem_stall = plan[j];
      @(posedge clk); #1;
    end
    bus.mem_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      model_mem[i] = 32'h0;
    end
    mem[12'h384 >> 2] = 32'h1122_3344; model_mem[12'h384 >> 2] = 32'h1122_3344;
    mem[12'h388 >> 2] = 32'hCAFE_F00D; model_mem[12'h388 >> 2] = 32'hCAFE_F00D;
    mem[12'h38C >> 2] = 32'hDEAD_BEEF; model_mem[12'h38C >> 2] = 32'hDEAD_BEEF;
    bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.mem_stall = 0;

    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_read",  {31'b0, bus.mem_read},  32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_addr",  {20'b0, bus.byte_address}, 32'h0);
    reset = 1'b1;

    // SW then LW, no stall
    do_req(1, 3'd2, 12'h380, 32'h0000_0007, 0, 0);
    do_req(0, 3'd2, 12'h380, 32'h0, 0, 0);
    chk("lw_lit", bus.resp_rdata, 32'h0000_0007);
    // LW with 4 stalled cycles
    do_req(0, 3'd2, 12'h380, 32'h0, 4, 0);
    chk("lw_stall_lit", bus.resp_rdata, 32'h0000_0007);
    // SB merge
    do_req(1, 3'd0, 12'h386, 32'h0000_00AB, 0, 0);
    chk("sb_mem_lit", mem[12'h384 >> 2], 32'h11AB_3344);
    // sign/zero extension
    do_req(1, 3'd2, 12'h380, 32'h80FF_7F01, 0, 2);
    do_req(0, 3'd0, 12'h381, 32'h0, 0, 0); chk("lb_lit",  bus.resp_rdata, 32'h0000_007F);
    do_req(0, 3'd4, 12'h381, 32'h0, 0, 0); chk("lbu_lit", bus.resp_rdata, 32'h0000_007F);
    do_req(0, 3'd1, 12'h382, 32'h0, 1, 0); chk("lh_lit",  bus.resp_rdata, 32'hFFFF_80FF);
    do_req(0, 3'd5, 12'h382, 32'h0, 0, 0); chk("lhu_lit", bus.resp_rdata, 32'h0000_80FF);
    do_req(0, 3'd0, 12'h383, 32'h0, 0, 0); chk("lb3_lit", bus.resp_rdata, 32'hFFFF_FF80);
    // SH merge with stalls in both phases, upper half
    do_req(1, 3'd1, 12'h38E, 32'h1234_5678, 2, 3);
    chk("sh_mem_lit", mem[12'h38C >> 2], 32'h5678_BEEF);
    // errors
    do_req(0, 3'd2, 12'h382, 32'h0, 0, 0); chk("err_lw_lit", {31'b0, bus.resp_error}, 32'h1);
    do_req(1, 3'd1, 12'h381, 32'h0, 0, 0); chk("err_sh_lit", {31'b0, bus.resp_error}, 32'h1);
    do_req(0, 3'd3, 12'h380, 32'h0, 0, 0); chk("err_f3_lit", bus.resp_rdata, 32'h0);
    do_req(1, 3'd4, 12'h380, 32'h0, 0, 0);
    // a good load after errors clears the error flag
    do_req(0, 3'd2, 12'h384, 32'h0, 0, 0);
    chk("after_err_lit", bus.resp_rdata, 32'h11AB_3344);

    // reset in the middle of an SB read phase
    begin
      int c;
      c = cyc;
      bus.req_valid = 1; bus.req_write = 1; bus.req_funct3 = 3'd0;
      bus.req_addr = 12'h388; bus.req_wdata = 32'h55;
      q.push_back(mk(c + 1, 1, 0, 12'h388, 0, 0, 0, 0));
      q.push_back(mk(c + 2, 1, 0, 12'h388, 0, 0, 0, 0));
      @(posedge clk); #1;
      bus.req_valid = 0; bus.mem_stall = 1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_read",  {31'b0, bus.mem_read},  32'h0);
      chk("rst_mid_write", {31'b0, bus.mem_write}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1; bus.mem_stall = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("rst_mem_lit", mem[12'h388 >> 2], 32'hCAFE_F00D);
    end
    // unit still works after the abandoned access
    do_req(0, 3'd5, 12'h388, 32'h0, 1, 0);
    chk("post_rst_lit", bus.resp_rdata, 32'h0000_F00D);

    for (int i = 12'h380 >> 2; i <= (12'h38C >> 2); i++) chk("mem_model", mem[i], model_mem[i]);
    chk("queue_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
